fltr_rr_sched: RTL and testbench

Round-robin scheduler that time-shares one 1-bit filter instance (the `intf_fltr` datapath: `clk`, `in`, `out`) between `N_CH` requesters. Each grant runs for a bounded burst. In `MD_SKIP` mode a flush gap follows each burst so filter state from one owner never reaches the next. The block sits between the channel front-ends and the single filter, muxes the filter input, and routes the delayed filter output back to the owning channel.

---
 rtl/fltr_rr_sched_pkg.sv | 24 ++
 rtl/fltr_rr_sched_rr_pick.sv | 32 +++
 rtl/fltr_rr_sched.sv | 159 +++++++++++++++
 tb/tb_fltr_rr_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fltr_rr_sched_pkg.sv
// Shared types for the round-robin filter scheduler: mode, FSM state, owner index
// and the return-path pipe entry.
package fltr_rr_sched_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_SKIP = 1'b1
    } enTASK2_MODE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FLUSH = 2'd2
    } enFLTR_SCHED_ST;

    typedef logic [3:0] u4_t;

    // One stage of the return path: was this filter sample real, and whose was it
    typedef struct packed {
        logic vld;
        u4_t  own;
    } pipe_ent_t;

endpackage

// File: rtl/fltr_rr_sched_rr_pick.sv
// Combinational round-robin picker: the first requester found after 'last',
// wrapping around, so 'last' itself has the lowest priority.
module rr_pick
    import fltr_rr_sched_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] req,
    input  u4_t             last,
    output u4_t             winner,
    output logic            found
);

    int idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Walk from the farthest offset down so the nearest requester wins last
        for (int off = N_CH; off >= 1; off--) begin
            idx = (int'(last) + off) % N_CH;
            for (int j = 0; j < N_CH; j++) begin
                if (j == idx && req[j]) begin
                    winner = u4_t'(j);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fltr_rr_sched.sv
// Time-shares one 1-bit filter between N_CH channels in bounded round-robin bursts,
// with an optional flush gap, and routes the delayed filter output back to its owner.
module fltr_rr_sched
    import fltr_rr_sched_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int BURST = 8,
    parameter int FLUSH = 3,
    parameter int LAT   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  enTASK2_MODE     mode,
    input  logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] ch_in,
    output logic [N_CH-1:0] gnt,
    output logic            flt_in,
    input  logic            flt_out,
    output logic [N_CH-1:0] ch_out,
    output logic [N_CH-1:0] ch_vld,
    output logic            busy
);

    localparam int CMAX = (BURST > FLUSH) ? BURST : FLUSH;
    localparam int CW   = $clog2(CMAX + 1);

    enFLTR_SCHED_ST  state_q, state_d;
    u4_t             owner_q, owner_d;
    u4_t             last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0] gnt_q, gnt_d;
    pipe_ent_t       pipe_q [LAT];
    pipe_ent_t       pipe_d [LAT];
    pipe_ent_t       head;

    u4_t  winner;
    logic found;
    logic smp_vld;
    logic own_req;
    logic own_in;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        own_req = 1'b0;
        own_in  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (owner_q == u4_t'(i)) begin
                own_req = req[i];
                own_in  = ch_in[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        flt_in  = 1'b0;
        smp_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    owner_d = winner;
                    last_d  = winner;
                    cnt_d   = '0;
                    gnt_d   = '0;
                    for (int i = 0; i < N_CH; i++) gnt_d[i] = (winner == u4_t'(i));
                end
            end
            ST_GRANT: begin
                flt_in  = own_in;
                smp_vld = own_req;
                cnt_d   = cnt_q + CW'(1);
                if (!own_req || cnt_q == CW'(BURST - 1)) begin
                    gnt_d = '0;
                    cnt_d = '0;
                    if (mode == MD_SKIP) begin
                        state_d = ST_FLUSH;
                    end else if (found) begin
                        owner_d = winner;
                        last_d  = winner;
                        for (int i = 0; i < N_CH; i++) gnt_d[i] = (winner == u4_t'(i));
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(FLUSH - 1)) begin
                    cnt_d = '0;
                    if (found) begin
                        state_d = ST_GRANT;
                        owner_d = winner;
                        last_d  = winner;
                        for (int i = 0; i < N_CH; i++) gnt_d[i] = (winner == u4_t'(i));
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Return path: tag every filter input sample with its owner and validity
    always_comb begin
        pipe_d[0] = '{vld: smp_vld, own: owner_q};
        for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= u4_t'(N_CH - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            for (int i = 0; i < LAT; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign head = pipe_q[LAT-1];

    always_comb begin
        ch_vld = '0;
        ch_out = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (head.vld && head.own == u4_t'(i)) begin
                ch_vld[i] = 1'b1;
                ch_out[i] = flt_out;
            end
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fltr_rr_sched.sv
// Directed bench for fltr_rr_sched with a pure LAT-cycle delay standing in for the filter.
module tb_fltr_rr_sched;
    import fltr_rr_sched_pkg::*;

    localparam int N_CH  = 4;
    localparam int BURST = 8;
    localparam int FLUSH = 3;
    localparam int LAT   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    enTASK2_MODE     mode;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] ch_in;
    logic [N_CH-1:0] gnt;
    logic            flt_in;
    logic            flt_out;
    logic [N_CH-1:0] ch_out;
    logic [N_CH-1:0] ch_vld;
    logic            busy;

    logic [LAT-1:0]  dly = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) dly <= {dly[LAT-2:0], flt_in};
    assign flt_out = dly[LAT-1];

    fltr_rr_sched #(
        .N_CH  (N_CH),
        .BURST (BURST),
        .FLUSH (FLUSH),
        .LAT   (LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .req     (req),
        .ch_in   (ch_in),
        .gnt     (gnt),
        .flt_in  (flt_in),
        .flt_out (flt_out),
        .ch_out  (ch_out),
        .ch_vld  (ch_vld),
        .busy    (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ch_in = '0;
        mode  = MD_IDLE;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Skip-mode grant pattern with req=0011: 8 x ch0, 3 flush, 8 x ch1, 3 flush
    function automatic logic [3:0] skip_gnt(input int k);
        int p;
        if (k < 0) return 4'b0000;
        p = k % 22;
        if (p < 8)  return 4'b0001;
        if (p < 11) return 4'b0000;
        if (p < 19) return 4'b0010;
        return 4'b0000;
    endfunction

    initial begin
        logic [15:0] pat;
        logic [3:0]  e;
        int          cnt2;

        rst_n = 1'b0;
        req   = '0;
        ch_in = '0;
        mode  = MD_IDLE;
        #2;
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_vld", ch_vld, 0);
        check_eq("rst_out", ch_out, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("idle_busy", busy, 0);

        // Single requester, back-to-back re-grant, return path
        pat = 16'b1011_0010_0110_1101;
        req = 4'b0001;
        tick();
        for (int j = 0; j < 16; j++) begin
            ch_in = {3'b000, pat[j]};
            check_eq("single_gnt", gnt, 4'b0001);
            check_eq("single_busy", busy, 1);
            check_eq("single_vld", ch_vld, (j >= LAT) ? 4'b0001 : 4'b0000);
            check_eq("single_out", ch_out, (j >= LAT) ? {3'b000, pat[j-LAT]} : 4'b0000);
            tick();
        end
        req = '0;
        tick();
        check_eq("single_rel_gnt", gnt, 0);
        check_eq("single_rel_busy", busy, 0);

        // Round-robin order 0,1,2,3,0 from reset
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 40; k++) begin
            check_eq("rr_gnt", gnt, 4'b0001 << ((k / BURST) % N_CH));
            tick();
        end

        // Skip mode with flush gaps
        do_reset();
        mode  = MD_SKIP;
        req   = 4'b0011;
        ch_in = 4'b1111;
        tick();
        for (int k = 0; k < 25; k++) begin
            e = skip_gnt(k);
            check_eq("skip_gnt", gnt, e);
            check_eq("skip_flt_in", flt_in, (e != 0) ? 1 : 0);
            check_eq("skip_busy", busy, 1);
            check_eq("skip_vld", ch_vld, skip_gnt(k - LAT));
            check_eq("skip_out", ch_out, skip_gnt(k - LAT));
            tick();
        end

        // Early release of channel 2 after three samples
        do_reset();
        req   = 4'b1100;
        ch_in = 4'b0100;
        tick();
        cnt2 = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) req = 4'b1000;
            check_eq("early_gnt", gnt, (k < 4) ? 4'b0100 : 4'b1000);
            if (k < 2 || k == 5)       e = 4'b0000;
            else if (k <= 4)           e = 4'b0100;
            else                       e = 4'b1000;
            check_eq("early_vld", ch_vld, e);
            cnt2 += int'(ch_vld[2]);
            tick();
        end
        check_eq("early_pulses", cnt2, 3);

        // Mode change mid-burst takes effect only at burst end
        do_reset();
        req   = 4'b0011;
        ch_in = 4'b0000;
        tick();
        for (int k = 0; k < 15; k++) begin
            if (k == 4) mode = MD_SKIP;
            if (k < 8)       e = 4'b0001;
            else if (k < 11) e = 4'b0000;
            else             e = 4'b0010;
            check_eq("mode_gnt", gnt, e);
            tick();
        end
        check_eq("mode_vld_pre_rst", ch_vld, 4'b0010);

        // Reset mid-burst with results in flight
        mode  = MD_IDLE;
        req   = 4'b1111;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_gnt", gnt, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_vld", ch_vld, 0);
        check_eq("rst_mid_out", ch_out, 0);
        check_eq("rst_mid_flt_in", flt_in, 0);
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_rel_gnt0", gnt, 0);
        tick();
        check_eq("rst_rel_gnt", gnt, 4'b0001);
        check_eq("rst_rel_vld", ch_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
